xyj_disp_scan: RTL and testbench
================================

Name: xyj_disp_scan

Overview:
- Display-side counterpart of the washer controller: consumes the controller's phase and remaining-seconds countdown and drives a 4-digit multiplexed 7-segment display.
- Snapshots inputs once per scan frame, converts binary seconds to BCD with a sequential subtract FSM, and scans digits round-robin.
- Blinks the seconds digits while the cycle is paused or finished.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; must be >= 8.
- BLINK_DIV, 25000000, clk cycles per blink half-period.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- phase  input  3  0 idle, 1 wash1, 2 spin1, 3 wash2, 4 spin2, 5 done, 6-7 unused
- sec_in  input  6  remaining seconds of the current phase (binary)
- stop_in  input  1  pause indicator from the controller
- seg  output  [0:6]  segments a..g (seg[0]=a), active-high, registered
- dig_sel  output  [0:3]  one-hot digit enable, active-high, registered; dig_sel[0] is the leftmost digit
- frame_tick  output  1  one-cycle pulse when a new frame snapshot is taken

Behaviour:
- Reset (rst=0, asynchronous):
  - seg=0000000, dig_sel=0000, frame_tick=0.
  - scan_cnt=0, idx=0, snapshots=0, tens_r=0, ones_r=0.
  - Conversion FSM in IDLE; blink_on=1, blink_cnt=0.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1. At its terminal count, idx advances 0->1->2->3->0 and scan_cnt returns to 0.
  - dig_sel and seg update on the same edge as idx and hold for a full slot. dig_sel = one-hot of idx.
- Frame start (terminal count while idx=3):
  - Capture sec_in->sec_s, phase->ph_s, stop_in->stop_s; pulse frame_tick for 1 cycle.
  - Start conversion.
  - Mid-frame input changes have no effect until the next frame.
- Conversion FSM, states IDLE -> SUB -> DONE -> IDLE:
  - On start: rem=sec_s, tens=0, enter SUB.
  - SUB, each cycle: if rem>=10, then rem-=10 and tens+=1; else go to DONE.
  - DONE: load tens_r=tens, ones_r=rem[3:0], return to IDLE.
  - Worst case (63) takes 8 cycles, which fits inside slot 0 because SCAN_DIV>=8. Digits 2-3 are shown in slots 2-3, so no torn values are ever displayed.
  - A start arriving while not IDLE cannot occur under the SCAN_DIV constraint. No restart is required.
- Glyphs (a..g):
  - Digits: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Symbols: '-'=0000001, 'E'=1001111, 'P'=1100111, blank=0000000.
- Digit content:
  - Digit 0: ph_s 0 shows '-'; 1..4 show digit 1..4; 5 shows 'E'; 6-7 show blank.
  - Digit 1: 'P' when stop_s=1, else blank.
  - Digits 2, 3: tens_r and ones_r. If sec_s>59, both show '-'.
- Blink:
  - Active when stop_s=1 or ph_s=5. While active, blink_cnt counts 0..BLINK_DIV-1 and toggles blink_on at terminal count.
  - When inactive, blink_cnt is held at 0 and blink_on at 1.
  - Digits 2-3 are blank while blink_on=0. dig_sel still scans.
- Reset mid-frame: everything returns to reset values immediately. The first valid frame appears after 4 slots.

Optional Feature:
- LEAD_ZERO_BLANK_EN
  - Defined: digit 2 shows blank when tens_r=0 and sec_s<=59, so "07" is displayed as " 7".
  - Undefined: the leading zero is shown, so "07" is displayed as "07".
  - Digit 3 always shows its value either way.

Test Plan:
- (All scenarios use SCAN_DIV=8, BLINK_DIV=64.)
- Reset: hold rst=0 for 5 cycles, release -> seg=0000000 and dig_sel=0000 during reset. dig_sel=1000 after the first slot boundary, then rotates 0100, 0010, 0001 every 8 cycles.
- phase=1, sec_in=25, stop_in=0 -> in the frame after the snapshot:
  - slot 0: seg=0110000 ('1')
  - slot 1: blank
  - slot 2: 1101101 ('2')
  - slot 3: 1011011 ('5')
- sec_in=63 -> conversion completes within 8 cycles of frame_tick; slots 2 and 3 show 0000001 ('-').
- sec_in=7 -> slot 2 shows 1111110 with LEAD_ZERO_BLANK_EN undefined and 0000000 with it defined; slot 3 shows 1110000.
- phase=5 or stop_in=1 -> slot 0 shows 'E' (or slot 1 shows 'P'). Slots 2-3 alternate between the value and blank every 64 cycles, and dig_sel keeps rotating.
- Change sec_in from 30 to 12 in the middle of slot 2 -> slots 2-3 keep showing 3/0 until the next frame, then 1/2. Asserting rst=0 during slot 2 clears seg and dig_sel asynchronously, before the next clock edge.

Source files
------------

// File: rtl/xyj_disp_scan.sv
// Four-digit multiplexed 7-segment driver for the washer controller: phase, pause flag and remaining seconds.
// Optional build macro LEAD_ZERO_BLANK_EN blanks a leading zero in the tens digit.
module xyj_disp_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] phase,
    input  logic [5:0] sec_in,
    input  logic       stop_in,
    output logic [0:6] seg,
    output logic [0:3] dig_sel,
    output logic       frame_tick
);

    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] G_BLANK = 7'b0000000;
    localparam logic [6:0] G_DASH  = 7'b0000001;
    localparam logic [6:0] G_E     = 7'b1001111;
    localparam logic [6:0] G_P     = 7'b1100111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } conv_state_t;

    // Decimal digit to segment pattern, bit 6 = segment a.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1111110;
            4'd1:    g = 7'b0110000;
            4'd2:    g = 7'b1101101;
            4'd3:    g = 7'b1111001;
            4'd4:    g = 7'b0110011;
            4'd5:    g = 7'b1011011;
            4'd6:    g = 7'b1011111;
            4'd7:    g = 7'b1110000;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1111011;
            default: g = 7'b0000000;
        endcase
        return g;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [1:0]         idx_r;
    logic               term_s;
    logic               frame_start_s;
    logic [5:0]         sec_snap_r;
    logic [2:0]         ph_snap_r;
    logic               stop_snap_r;
    conv_state_t        state_r, state_n;
    logic [5:0]         rem_r, rem_n;
    logic [2:0]         tens_cnt_r, tens_cnt_n;
    logic [2:0]         tens_r, tens_n;
    logic [3:0]         ones_r, ones_n;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               blink_on_r;
    logic               blink_act_s;
    logic               over_s;
    logic [6:0]         slot_glyph_s;
    logic [6:0]         seg_r;
    logic [3:0]         dig_sel_r;
    logic               frame_tick_r;

    assign term_s        = (scan_cnt_r == SCAN_W'(SCAN_DIV - 1));
    assign frame_start_s = term_s && (idx_r == 2'd3);
    assign blink_act_s   = stop_snap_r || (ph_snap_r == 3'd5);
    assign over_s        = (sec_snap_r > 6'd59);

    // Slot timer, digit index and per-frame input snapshot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_r  <= '0;
            idx_r       <= 2'd0;
            sec_snap_r  <= 6'd0;
            ph_snap_r   <= 3'd0;
            stop_snap_r <= 1'b0;
        end else if (term_s) begin
            scan_cnt_r <= '0;
            idx_r      <= idx_r + 2'd1;
            if (frame_start_s) begin
                sec_snap_r  <= sec_in;
                ph_snap_r   <= phase;
                stop_snap_r <= stop_in;
            end
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Conversion FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            rem_r      <= 6'd0;
            tens_cnt_r <= 3'd0;
            tens_r     <= 3'd0;
            ones_r     <= 4'd0;
        end else begin
            state_r    <= state_n;
            rem_r      <= rem_n;
            tens_cnt_r <= tens_cnt_n;
            tens_r     <= tens_n;
            ones_r     <= ones_n;
        end
    end

    // Repeated subtract-by-ten; the start loads sec_in directly since the snapshot lands on the same edge.
    always_comb begin
        state_n    = state_r;
        rem_n      = rem_r;
        tens_cnt_n = tens_cnt_r;
        tens_n     = tens_r;
        ones_n     = ones_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start_s) begin
                    rem_n      = sec_in;
                    tens_cnt_n = 3'd0;
                    state_n    = ST_SUB;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SUB: begin
                if (rem_r >= 6'd10) begin
                    rem_n      = rem_r - 6'd10;
                    tens_cnt_n = tens_cnt_r + 3'd1;
                end else begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                tens_n  = tens_cnt_r;
                ones_n  = rem_r[3:0];
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Blink timer, parked at "on" whenever blinking is not wanted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (!blink_act_s) begin
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
        end else if (blink_cnt_r == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_r <= '0;
            blink_on_r  <= ~blink_on_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Glyph for the digit about to be enabled.
    always_comb begin
        slot_glyph_s = G_BLANK;
        case (idx_r)
            2'd0: begin
                case (ph_snap_r)
                    3'd0:    slot_glyph_s = G_DASH;
                    3'd1, 3'd2, 3'd3, 3'd4:
                             slot_glyph_s = digit_glyph({1'b0, ph_snap_r});
                    3'd5:    slot_glyph_s = G_E;
                    default: slot_glyph_s = G_BLANK;
                endcase
            end
            2'd1: begin
                if (stop_snap_r) begin
                    slot_glyph_s = G_P;
                end else begin
                    slot_glyph_s = G_BLANK;
                end
            end
            2'd2: begin
                if (!blink_on_r) begin
                    slot_glyph_s = G_BLANK;
                end else if (over_s) begin
                    slot_glyph_s = G_DASH;
`ifdef LEAD_ZERO_BLANK_EN
                end else if (tens_r == 3'd0) begin
                    slot_glyph_s = G_BLANK;
`endif
                end else begin
                    slot_glyph_s = digit_glyph({1'b0, tens_r});
                end
            end
            2'd3: begin
                if (!blink_on_r) begin
                    slot_glyph_s = G_BLANK;
                end else if (over_s) begin
                    slot_glyph_s = G_DASH;
                end else begin
                    slot_glyph_s = digit_glyph(ones_r);
                end
            end
            default: slot_glyph_s = G_BLANK;
        endcase
    end

    // Output registers; digit enable and segments change together at the slot boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_r        <= 7'b0000000;
            dig_sel_r    <= 4'b0000;
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= frame_start_s;
            if (term_s) begin
                seg_r     <= slot_glyph_s;
                dig_sel_r <= 4'b1000 >> idx_r;
            end else begin
                seg_r     <= seg_r;
                dig_sel_r <= dig_sel_r;
            end
        end
    end

    assign seg        = seg_r;
    assign dig_sel    = dig_sel_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_xyj_disp_scan.sv
// Directed self-checking bench for xyj_disp_scan with SCAN_DIV=8, BLINK_DIV=64.
module tb_xyj_disp_scan;

    localparam logic [6:0] G0 = 7'b1111110;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G7 = 7'b1110000;
    localparam logic [6:0] G9 = 7'b1111011;
    localparam logic [6:0] GD = 7'b0000001;
    localparam logic [6:0] GE = 7'b1001111;
    localparam logic [6:0] GP = 7'b1100111;
    localparam logic [6:0] GB = 7'b0000000;
`ifdef LEAD_ZERO_BLANK_EN
    localparam logic [6:0] GLZ = GB;
`else
    localparam logic [6:0] GLZ = G0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] phase;
    logic [5:0] sec_in;
    logic       stop_in;
    logic [0:6] seg;
    logic [0:3] dig_sel;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    xyj_disp_scan #(.SCAN_DIV(8), .BLINK_DIV(64)) dut (
        .clk(clk), .rst(rst), .phase(phase), .sec_in(sec_in), .stop_in(stop_in),
        .seg(seg), .dig_sel(dig_sel), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 40);
        chk("frame_tick_seen", {7'd0, frame_tick}, 8'd1);
    endtask

    // Starting just after a snapshot edge, check the four slots of the following frame.
    task automatic check_slots(input string tag, input logic [6:0] g0, input logic [6:0] g1,
                               input logic [6:0] g2, input logic [6:0] g3);
        logic [6:0] e[4];
        logic [3:0] oh;
        e[0] = g0; e[1] = g1; e[2] = g2; e[3] = g3;
        for (int s = 0; s < 4; s++) begin
            repeat (8) @(negedge clk);
            oh = 4'b1000 >> s;
            chk($sformatf("%s_dig%0d", tag, s), {4'd0, dig_sel}, {4'd0, oh});
            chk($sformatf("%s_seg%0d", tag, s), {1'b0, seg}, {1'b0, e[s]});
        end
    endtask

    initial begin
        rst = 1'b0; phase = 3'd1; sec_in = 6'd25; stop_in = 1'b0;
        #1;
        chk("rst_seg", {1'b0, seg}, 8'd0);
        chk("rst_dig", {4'd0, dig_sel}, 8'd0);
        chk("rst_tick", {7'd0, frame_tick}, 8'd0);
        repeat (5) @(negedge clk);
        chk("rst_seg_held", {1'b0, seg}, 8'd0);
        rst = 1'b1;

        repeat (7) @(negedge clk);
        chk("pre_slot_dig", {4'd0, dig_sel}, 8'd0);
        @(negedge clk);
        chk("first_dig", {4'd0, dig_sel}, 8'b0000_1000);
        chk("first_seg", {1'b0, seg}, {1'b0, GD});
        repeat (8) @(negedge clk);
        chk("rot1_dig", {4'd0, dig_sel}, 8'b0000_0100);
        chk("rot1_seg", {1'b0, seg}, {1'b0, GB});
        repeat (8) @(negedge clk);
        chk("rot2_dig", {4'd0, dig_sel}, 8'b0000_0010);
        chk("rot2_seg", {1'b0, seg}, {1'b0, GLZ});
        repeat (8) @(negedge clk);
        chk("rot3_dig", {4'd0, dig_sel}, 8'b0000_0001);
        chk("rot3_seg", {1'b0, seg}, {1'b0, G0});
        chk("first_tick", {7'd0, frame_tick}, 8'd1);
        @(negedge clk);
        chk("tick_pulse", {7'd0, frame_tick}, 8'd0);
        repeat (7) @(negedge clk);
        repeat (24) @(negedge clk);
        wait_frame();
        check_slots("s25", G1, GB, G2, G5);

        sec_in = 6'd63; wait_frame(); check_slots("s63", G1, GB, GD, GD);
        sec_in = 6'd60; wait_frame(); check_slots("s60", G1, GB, GD, GD);
        sec_in = 6'd59; wait_frame(); check_slots("s59", G1, GB, G5, G9);
        sec_in = 6'd7;  wait_frame(); check_slots("s07", G1, GB, GLZ, G7);

        // Mid-frame change only takes effect at the next snapshot.
        sec_in = 6'd30; wait_frame();
        repeat (8) @(negedge clk); chk("mid_s0", {1'b0, seg}, {1'b0, G1});
        repeat (8) @(negedge clk); chk("mid_s1", {1'b0, seg}, {1'b0, GB});
        repeat (8) @(negedge clk); chk("mid_s2", {1'b0, seg}, {1'b0, G3});
        repeat (4) @(negedge clk); sec_in = 6'd12;
        repeat (4) @(negedge clk); chk("mid_s3", {1'b0, seg}, {1'b0, G0});
        chk("mid_tick", {7'd0, frame_tick}, 8'd1);
        check_slots("s12", G1, GB, G1, G2);

        // Done phase: seconds blink with a 64-cycle half-period (two frames).
        phase = 3'd5; wait_frame();
        check_slots("done_f1", GE, GB, G1, G2);
        check_slots("done_f2", GE, GB, G1, G2);
        check_slots("done_f3", GE, GB, GB, GB);
        check_slots("done_f4", GE, GB, GB, GB);
        check_slots("done_f5", GE, GB, G1, G2);

        phase = 3'd2; wait_frame();
        check_slots("run_f", G2, GB, G1, G2);
        stop_in = 1'b1; wait_frame();
        check_slots("stop_f1", G2, GP, G1, G2);
        check_slots("stop_f2", G2, GP, G1, G2);
        check_slots("stop_f3", G2, GP, GB, GB);

        // Asynchronous reset in the middle of slot 2.
        stop_in = 1'b0;
        repeat (24) @(negedge clk);
        chk("pre_arst_dig", {4'd0, dig_sel}, 8'b0000_0010);
        #2 rst = 1'b0;
        #1;
        chk("arst_seg", {1'b0, seg}, 8'd0);
        chk("arst_dig", {4'd0, dig_sel}, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_arst_dig", {4'd0, dig_sel}, 8'b0000_1000);
        chk("post_arst_seg", {1'b0, seg}, {1'b0, GD});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
